// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and syscall serialisation.
// Bubbles are all-zero bundles with ex_valid low; stall freezes PC and IF/ID upstream.
module id_ex_stage #(
    parameter int DRAIN_CYCLES = 3,
    parameter int WIDTH        = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] id_instr,
    input  logic [WIDTH-1:0] id_pc4,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [4:0]       id_EX_D,
    input  logic [2:0]       id_MEM_D,
    input  logic [1:0]       id_WB_D,
    input  logic             id_jump,
    input  logic             id_branch,
    input  logic             id_syscall,
    input  logic             id_jr,
    input  logic             id_jal,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_instr,
    output logic [WIDTH-1:0] ex_pc4,
    output logic [WIDTH-1:0] ex_rs_data,
    output logic [WIDTH-1:0] ex_rt_data,
    output logic [4:0]       ex_EX_D,
    output logic [2:0]       ex_MEM_D,
    output logic [1:0]       ex_WB_D,
    output logic             ex_jump,
    output logic             ex_branch,
    output logic             ex_syscall,
    output logic             ex_jr,
    output logic             ex_jal
);

    typedef enum logic [1:0] {RUN, LOAD_STALL, SC_DRAIN, SC_PASS} state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             valid_q;
    logic [WIDTH-1:0] instr_q, pc4_q, rs_q, rt_q;
    logic [4:0]       exd_q;
    logic [2:0]       memd_q;
    logic [1:0]       wbd_q;
    logic             jump_q, branch_q, syscall_q, jr_q, jal_q;

    logic             load_hz;
    logic             capture;
    logic             stall_c;
    logic [4:0]       ex_rt;

    assign ex_rt   = instr_q[20:16];
    assign load_hz = valid_q && memd_q[1] && (ex_rt != 5'd0) &&
                     ((ex_rt == id_instr[25:21]) || (ex_rt == id_instr[20:16]));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        capture = 1'b0;
        case (state_q)
            SC_DRAIN: begin
                if (flush) begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end else if (cnt_q != 3'd0) begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - 3'd1;
                end else begin
                    capture = 1'b1;
                    state_d = SC_PASS;
                end
            end
            default: begin
                // RUN, LOAD_STALL and SC_PASS share one decision; SC_PASS only
                // masks the syscall so the one just issued cannot re-drain.
                if (flush) begin
                    state_d = RUN;
                end else if (load_hz) begin
                    stall_c = 1'b1;
                    state_d = LOAD_STALL;
                end else if (id_syscall && state_q != SC_PASS) begin
                    stall_c = 1'b1;
                    cnt_d   = 3'(DRAIN_CYCLES - 1);
                    state_d = SC_DRAIN;
                end else begin
                    capture = 1'b1;
                    state_d = RUN;
                end
            end
        endcase
    end

    assign stall = stall_c & rst_b;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Whole bundle loads together: either the ID instruction or a zero bubble.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_q   <= 1'b0;
            instr_q   <= '0;
            pc4_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            exd_q     <= '0;
            memd_q    <= '0;
            wbd_q     <= '0;
            jump_q    <= 1'b0;
            branch_q  <= 1'b0;
            syscall_q <= 1'b0;
            jr_q      <= 1'b0;
            jal_q     <= 1'b0;
        end else if (capture) begin
            valid_q   <= 1'b1;
            instr_q   <= id_instr;
            pc4_q     <= id_pc4;
            rs_q      <= id_rs_data;
            rt_q      <= id_rt_data;
            exd_q     <= id_EX_D;
            memd_q    <= id_MEM_D;
            wbd_q     <= id_WB_D;
            jump_q    <= id_jump;
            branch_q  <= id_branch;
            syscall_q <= id_syscall | (state_q == SC_DRAIN);
            jr_q      <= id_jr;
            jal_q     <= id_jal;
        end else begin
            valid_q   <= 1'b0;
            instr_q   <= '0;
            pc4_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            exd_q     <= '0;
            memd_q    <= '0;
            wbd_q     <= '0;
            jump_q    <= 1'b0;
            branch_q  <= 1'b0;
            syscall_q <= 1'b0;
            jr_q      <= 1'b0;
            jal_q     <= 1'b0;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_instr   = instr_q;
    assign ex_pc4     = pc4_q;
    assign ex_rs_data = rs_q;
    assign ex_rt_data = rt_q;
    assign ex_EX_D    = exd_q;
    assign ex_MEM_D   = memd_q;
    assign ex_WB_D    = wbd_q;
    assign ex_jump    = jump_q;
    assign ex_branch  = branch_q;
    assign ex_syscall = syscall_q;
    assign ex_jr      = jr_q;
    assign ex_jal     = jal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus randomized bench for id_ex_stage against a cycle-level reference model.
module tb_id_ex_stage;

    localparam int W = 32;
    localparam int D = 3;

    logic          clk = 1'b0;
    logic          rst_b;
    logic [W-1:0]  id_instr, id_pc4, id_rs_data, id_rt_data;
    logic [4:0]    id_EX_D;
    logic [2:0]    id_MEM_D;
    logic [1:0]    id_WB_D;
    logic          id_jump, id_branch, id_syscall, id_jr, id_jal, flush;
    logic          stall, ex_valid;
    logic [W-1:0]  ex_instr, ex_pc4, ex_rs_data, ex_rt_data;
    logic [4:0]    ex_EX_D;
    logic [2:0]    ex_MEM_D;
    logic [1:0]    ex_WB_D;
    logic          ex_jump, ex_branch, ex_syscall, ex_jr, ex_jal;

    id_ex_stage #(.DRAIN_CYCLES(D), .WIDTH(W)) dut (
        .clk(clk), .rst_b(rst_b),
        .id_instr(id_instr), .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_EX_D(id_EX_D), .id_MEM_D(id_MEM_D), .id_WB_D(id_WB_D),
        .id_jump(id_jump), .id_branch(id_branch), .id_syscall(id_syscall),
        .id_jr(id_jr), .id_jal(id_jal), .flush(flush),
        .stall(stall), .ex_valid(ex_valid),
        .ex_instr(ex_instr), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_EX_D(ex_EX_D), .ex_MEM_D(ex_MEM_D), .ex_WB_D(ex_WB_D),
        .ex_jump(ex_jump), .ex_branch(ex_branch), .ex_syscall(ex_syscall),
        .ex_jr(ex_jr), .ex_jal(ex_jal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         v;
        logic [31:0]  instr, pc4, rs, rt;
        logic [4:0]   exd;
        logic [2:0]   memd;
        logic [1:0]   wbd;
        logic         j, b, s, jr, jal;
    } bun_t;

    bun_t m_ex;
    int   drain_left;   // -1 when no syscall drain is in progress
    bit   just_issued;  // syscall left the drain last cycle
    int   tests = 0;
    int   fails = 0;

    localparam logic [31:0] ADDI = 32'h20080005;
    localparam logic [31:0] LW0  = 32'h8D280000;
    localparam logic [31:0] LWZ  = 32'h8D200000;
    localparam logic [31:0] LW1  = 32'h8D090000;
    localparam logic [31:0] ADD0 = 32'h01084020;
    localparam logic [31:0] ADD1 = 32'h01294020;
    localparam logic [31:0] SYSC = 32'h0000000C;

    function automatic bun_t id_bun();
        return {1'b1, id_instr, id_pc4, id_rs_data, id_rt_data, id_EX_D, id_MEM_D, id_WB_D,
                id_jump, id_branch, id_syscall, id_jr, id_jal};
    endfunction

    function automatic bun_t dut_bun();
        return {ex_valid, ex_instr, ex_pc4, ex_rs_data, ex_rt_data, ex_EX_D, ex_MEM_D, ex_WB_D,
                ex_jump, ex_branch, ex_syscall, ex_jr, ex_jal};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_bun(input string tag, input bun_t exp);
        bun_t got;
        got = dut_bun();
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic [4:0] exd, input logic [2:0] memd,
                         input logic [1:0] wbd, input logic sc, input logic fl);
        id_instr   = ins;      id_EX_D  = exd;  id_MEM_D = memd; id_WB_D = wbd;
        id_syscall = sc;       flush    = fl;
        id_pc4     = $urandom; id_rs_data = $urandom; id_rt_data = $urandom;
        id_jump    = 1'($urandom); id_branch = 1'($urandom);
        id_jr      = 1'($urandom); id_jal    = 1'($urandom);
    endtask

    task automatic model_reset();
        m_ex        = '0;
        drain_left  = -1;
        just_issued = 0;
    endtask

    // One clock: check combinational stall mid-cycle, then the EX bundle after the edge.
    task automatic step(output logic st);
        logic hz, es;
        bun_t nx;
        bit   was_issued;
        @(negedge clk);
        hz = m_ex.v && m_ex.memd[1] && (m_ex.instr[20:16] != 5'd0) &&
             (m_ex.instr[20:16] == id_instr[25:21] || m_ex.instr[20:16] == id_instr[20:16]);
        was_issued  = just_issued;
        just_issued = 0;
        es = 1'b0;
        nx = '0;
        if (drain_left >= 0) begin
            if (flush)               drain_left = -1;
            else if (drain_left > 0) begin es = 1'b1; drain_left--; end
            else begin
                nx = id_bun(); nx.s = 1'b1;
                drain_left = -1; just_issued = 1;
            end
        end else if (flush)                  ;
        else if (hz)                         es = 1'b1;
        else if (id_syscall && !was_issued)  begin es = 1'b1; drain_left = D - 1; end
        else                                 nx = id_bun();
        st = stall;
        chk("stall", {31'd0, stall}, {31'd0, es});
        @(posedge clk);
        #1;
        m_ex = nx;
        chk_bun("ex_bundle", m_ex);
    endtask

    initial begin
        logic st;
        int   nstall;
        model_reset();
        rst_b = 1'b0;
        drive(32'd0, 5'd0, 3'd0, 2'd0, 1'b0, 1'b0);
        #12;
        chk_bun("reset_bundle", '0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk); #1;

        // Straight-line ADDI
        drive(ADDI, 5'b01010, 3'b001, 2'b10, 1'b0, 1'b0);
        step(st);
        chk("addi_stall", {31'd0, st}, 32'd0);
        chk("addi_instr", ex_instr, ADDI);
        chk("addi_ctl", {20'd0, ex_EX_D, ex_MEM_D, ex_WB_D, ex_valid, 1'b0}, {20'd0, 5'b01010, 3'b001, 2'b10, 1'b1, 1'b0});

        // Asynchronous reset mid-stream with a syscall pending in ID
        drive(ADDI, 5'b01010, 3'b001, 2'b10, 1'b1, 1'b0);
        #2 rst_b = 1'b0;
        #1;
        chk_bun("midreset_bundle", '0);
        chk("midreset_stall", {31'd0, stall}, 32'd0);
        id_syscall = 1'b0;
        #1 rst_b = 1'b1;
        model_reset();
        step(st);
        chk("post_reset_valid", {31'd0, ex_valid}, 32'd1);

        // Load-use hazard
        drive(LW0, 5'b00100, 3'b011, 2'b11, 1'b0, 1'b0);
        step(st);
        drive(ADD0, 5'b10000, 3'b001, 2'b10, 1'b0, 1'b0);
        step(st);
        chk("lu_stall", {31'd0, st}, 32'd1);
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        step(st);
        chk("lu_release", {31'd0, st}, 32'd0);
        chk("lu_add", ex_instr, ADD0);

        // Load into $zero never hazards
        drive(LWZ, 5'b00100, 3'b011, 2'b11, 1'b0, 1'b0);
        step(st);
        drive(32'h01004020, 5'b10000, 3'b001, 2'b10, 1'b0, 1'b0);
        step(st);
        chk("zero_nostall", {31'd0, st}, 32'd0);

        // Syscall drain, then holding id_syscall does not re-drain
        drive(SYSC, 5'd0, 3'd0, 2'd0, 1'b1, 1'b0);
        nstall = 0;
        for (int i = 0; i < D; i++) begin
            step(st);
            nstall += int'(st);
            chk("sc_bubble", {31'd0, ex_valid}, 32'd0);
        end
        chk("sc_drain_len", nstall, D);
        step(st);
        chk("sc_issue", {30'd0, st, ex_syscall & ex_valid}, 32'd1);
        step(st);
        chk("sc_no_redrain", {30'd0, st, ex_valid}, 32'd1);
        drive(ADDI, 5'b01010, 3'b001, 2'b10, 1'b0, 1'b0);
        step(st);

        // Flush beats a load-use hazard
        drive(LW0, 5'b00100, 3'b011, 2'b11, 1'b0, 1'b0);
        step(st);
        drive(ADD0, 5'b10000, 3'b001, 2'b10, 1'b0, 1'b1);
        step(st);
        chk("flush_lu", {30'd0, st, ex_valid}, 32'd0);
        flush = 1'b0;
        step(st);
        chk("flush_lu_next", ex_instr, ADD0);

        // Flush on the second drain cycle returns to RUN
        drive(SYSC, 5'd0, 3'd0, 2'd0, 1'b1, 1'b0);
        step(st);
        step(st);
        flush = 1'b1;
        step(st);
        chk("flush_sc", {30'd0, st, ex_valid}, 32'd0);
        drive(ADDI, 5'b01010, 3'b001, 2'b10, 1'b0, 1'b0);
        step(st);
        chk("flush_sc_run", {31'd0, st, ex_valid} == 32'd1 ? ex_instr : 32'hDEAD, ADDI);

        // Back-to-back dependent loads
        nstall = 0;
        drive(LW0, 5'b00100, 3'b011, 2'b11, 1'b0, 1'b0);
        step(st); nstall += int'(st);
        drive(LW1, 5'b00100, 3'b011, 2'b11, 1'b0, 1'b0);
        step(st); nstall += int'(st);
        step(st); nstall += int'(st);
        chk("b2b_lw1", ex_instr, LW1);
        drive(ADD1, 5'b10000, 3'b001, 2'b10, 1'b0, 1'b0);
        step(st); nstall += int'(st);
        step(st); nstall += int'(st);
        chk("b2b_add", ex_instr, ADD1);
        chk("b2b_stalls", nstall, 2);

        // Randomized traffic; ID holds its instruction while stalled
        st = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!st) begin
                drive({($urandom_range(0, 1) == 1) ? 6'h23 : 6'h00, 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 16'($urandom)},
                      5'($urandom), 3'($urandom), 2'($urandom),
                      ($urandom_range(0, 11) == 0), ($urandom_range(0, 9) == 0));
            end else begin
                flush = ($urandom_range(0, 9) == 0);
            end
            step(st);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
